// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants for axi_rd_arbiter: FSM state encodings, read-owner
// encoding and AXI response codes.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_AR   = 2'd1,
        ARB_R    = 2'd2
    } arb_state_e;

    localparam logic ARB_OWN_IFU = 1'b0;
    localparam logic ARB_OWN_EXU = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Instruction fetches are always full 32-bit words.
    localparam logic [2:0] IFU_ARSIZE = 3'b010;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Merges the core's fetch and load read ports onto one AXI4-Lite master, one
// read in flight, write channels passed through. Define ARB_TIMEOUT_EN for the read watchdog.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 10
) (
    input  logic        clock,
    input  logic        reset,
    // fetch read port
    input  logic        ifu_arvalid,
    input  logic [31:0] ifu_araddr,
    output logic        ifu_arready,
    output logic        bdu_rvalid,
    output logic [31:0] bdu_rdata,
    output logic [1:0]  bdu_rresp,
    input  logic        bdu_rready,
    // load read port
    input  logic        exu_arvalid,
    input  logic [31:0] exu_araddr,
    input  logic [2:0]  exu_arsize,
    output logic        exu_arready,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    input  logic        lsu_rready,
    // core write channels
    input  logic        exu_awvalid,
    input  logic [31:0] exu_awaddr,
    input  logic [2:0]  exu_awsize,
    output logic        exu_awready,
    input  logic        exu_wvalid,
    input  logic [31:0] exu_wdata,
    input  logic [3:0]  exu_wstrb,
    output logic        exu_wready,
    output logic        lsu_bvalid,
    output logic [1:0]  lsu_bresp,
    input  logic        lsu_bready,
    // downstream read channels
    output logic        m_arvalid,
    output logic [31:0] m_araddr,
    output logic [2:0]  m_arsize,
    input  logic        m_arready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    output logic        m_rready,
    // downstream write channels
    output logic        m_awvalid,
    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awsize,
    input  logic        m_awready,
    output logic        m_wvalid,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_wready,
    input  logic        m_bvalid,
    input  logic [1:0]  m_bresp,
    output logic        m_bready
);

    if (CNT_W < 1 || CNT_W > 30 || TIMEOUT_CYCLES < 1 || (TIMEOUT_CYCLES - 1) >= (1 << CNT_W)) begin : g_cfg_err
        $error("axi_rd_arbiter: CNT_W cannot hold TIMEOUT_CYCLES-1");
    end

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic        m_arvalid_q, m_arvalid_d;
    logic        wr_pend_q, wr_pend_d;
    logic        own_rready;
    logic        synth;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             synth_q, synth_d;
    logic             late_q, late_d;
    logic             timeout;

    assign timeout = (cnt_q == CNT_LAST);
    assign synth   = synth_q;
`else
    assign synth   = 1'b0;
`endif

    assign exu_awready = m_awready;
    assign exu_wready  = m_wready;
    assign lsu_bvalid  = m_bvalid;
    assign lsu_bresp   = m_bresp;
    assign m_awvalid   = exu_awvalid;
    assign m_awaddr    = exu_awaddr;
    assign m_awsize    = exu_awsize;
    assign m_wvalid    = exu_wvalid;
    assign m_wdata     = exu_wdata;
    assign m_wstrb     = exu_wstrb;
    assign m_bready    = lsu_bready;

    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = addr_q;
    assign m_arsize  = size_q;

    // Read data path is combinational so data reaches the owner in the m_rvalid cycle.
    always_comb begin
        own_rready = (owner_q == ARB_OWN_EXU) ? lsu_rready : bdu_rready;
        r_valid    = (state_q == ARB_R) && (synth || m_rvalid);
        r_data     = (state_q == ARB_R && !synth) ? m_rdata : 32'h0;
        r_resp     = (state_q != ARB_R) ? RESP_OKAY : (synth ? RESP_SLVERR : m_rresp);

        bdu_rvalid = r_valid && (owner_q == ARB_OWN_IFU);
        bdu_rdata  = (owner_q == ARB_OWN_IFU) ? r_data : 32'h0;
        bdu_rresp  = (owner_q == ARB_OWN_IFU) ? r_resp : RESP_OKAY;
        lsu_rvalid = r_valid && (owner_q == ARB_OWN_EXU);
        lsu_rdata  = (owner_q == ARB_OWN_EXU) ? r_data : 32'h0;
        lsu_rresp  = (owner_q == ARB_OWN_EXU) ? r_resp : RESP_OKAY;

        m_rready   = (state_q == ARB_R) && !synth && own_rready;
`ifdef ARB_TIMEOUT_EN
        // Swallow a response that arrives after its transaction timed out.
        m_rready   = m_rready || (state_q == ARB_IDLE && late_q);
`endif
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        size_d      = size_q;
        m_arvalid_d = m_arvalid_q;
        ifu_arready = 1'b0;
        exu_arready = 1'b0;

        wr_pend_d = wr_pend_q;
        if (m_awvalid && m_awready) begin
            wr_pend_d = 1'b1;
        end else if (m_bvalid && m_bready) begin
            wr_pend_d = 1'b0;
        end

`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        synth_d = synth_q;
        late_d  = late_q;
        if (state_q != ARB_IDLE && !timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == ARB_IDLE && m_rvalid) begin
            late_d = 1'b0;
        end
`endif

        case (state_q)
            ARB_IDLE: begin
                if (!wr_pend_q && (exu_arvalid || ifu_arvalid)) begin
                    if (exu_arvalid) begin
                        exu_arready = 1'b1;
                        owner_d     = ARB_OWN_EXU;
                        addr_d      = exu_araddr;
                        size_d      = exu_arsize;
                    end else begin
                        ifu_arready = 1'b1;
                        owner_d     = ARB_OWN_IFU;
                        addr_d      = ifu_araddr;
                        size_d      = IFU_ARSIZE;
                    end
                    state_d     = ARB_AR;
                    m_arvalid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            ARB_AR: begin
                if (m_arready) begin
                    state_d     = ARB_R;
                    m_arvalid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (timeout) begin
                    state_d     = ARB_R;
                    m_arvalid_d = 1'b0;
                    synth_d     = 1'b1;
`endif
                end
            end
            ARB_R: begin
`ifdef ARB_TIMEOUT_EN
                if (synth_q) begin
                    if (own_rready) begin
                        state_d = ARB_IDLE;
                        synth_d = 1'b0;
                    end
                end else if (m_rvalid && own_rready) begin
                    state_d = ARB_IDLE;
                end else if (timeout) begin
                    synth_d = 1'b1;
                    late_d  = 1'b1;
                end
`else
                if (m_rvalid && own_rready) begin
                    state_d = ARB_IDLE;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= ARB_OWN_IFU;
            addr_q      <= 32'h0;
            size_q      <= 3'b000;
            m_arvalid_q <= 1'b0;
            wr_pend_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
            synth_q     <= 1'b0;
            late_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            m_arvalid_q <= m_arvalid_d;
            wr_pend_q   <= wr_pend_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            synth_q     <= synth_d;
            late_q      <= late_d;
`endif
        end
    end

endmodule
